// File: rtl/pim_mac_if.sv
// Operand/result stream bundle between the bank read path, the PIM controller
// and the MAC engine.
`timescale 1ns/1ps
interface pim_mac_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 9
);
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    signed_mode;
  logic                    saturate;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] x_data;
  logic [LANES*DATA_W-1:0] w_data;
  logic                    res_valid;
  logic                    res_ready;
  logic [ACC_W-1:0]        res_data;
  logic                    res_overflow;
  logic                    busy;
  logic                    done;

  modport master (
    output start, len, signed_mode, saturate, in_valid, x_data, w_data, res_ready,
    input  in_ready, res_valid, res_data, res_overflow, busy, done
  );

  modport slave (
    input  start, len, signed_mode, saturate, in_valid, x_data, w_data, res_ready,
    output in_ready, res_valid, res_data, res_overflow, busy, done
  );
endinterface

// File: rtl/pim_mac_array.sv
// Multi-lane streaming dot-product engine with per-operation signedness,
// saturation and sticky overflow reporting.
//
// state  | meaning
// IDLE   | waiting for start; operation parameters latched here
// ACCUM  | accepting operand beats until the beat count is exhausted
// RESULT | presenting res_data until the consumer accepts it
`timescale 1ns/1ps
module pim_mac_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 9
) (
  input  logic     clk,
  input  logic     rst_n,
  pim_mac_if.slave bus
);

  // Two guard bits above ACC_W hold any acc + beat_sum exactly in either mode.
  localparam int EXT_W = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] S_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] S_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] U_MAX = {2'b00, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   remaining;
  logic               sgn_q, sat_q, ovf_q, done_q;
  logic               hs;
  logic signed [EXT_W-1:0] xe, we, beat_sum, acc_ext, acc_next;
  logic               too_high, too_low;
  logic [ACC_W-1:0]   acc_upd;

  assign hs = (state == ACCUM) && bus.in_valid;

  always_comb begin
    xe       = '0;
    we       = '0;
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      xe = {{(EXT_W-DATA_W){sgn_q & bus.x_data[i*DATA_W+DATA_W-1]}}, bus.x_data[i*DATA_W +: DATA_W]};
      we = {{(EXT_W-DATA_W){sgn_q & bus.w_data[i*DATA_W+DATA_W-1]}}, bus.w_data[i*DATA_W +: DATA_W]};
      beat_sum = beat_sum + xe * we;
    end
    acc_ext  = {{2{sgn_q & acc[ACC_W-1]}}, acc};
    acc_next = acc_ext + beat_sum;
    too_high = sgn_q ? (acc_next > S_MAX) : (acc_next > U_MAX);
    too_low  = sgn_q ? (acc_next < S_MIN) : acc_next[EXT_W-1];
    acc_upd  = acc_next[ACC_W-1:0];
    if (sat_q && too_high)
      acc_upd = sgn_q ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    else if (sat_q && too_low)
      acc_upd = sgn_q ? {1'b1, {(ACC_W-1){1'b0}}} : '0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (bus.len == '0) ? RESULT : ACCUM;
      ACCUM:   if (hs && remaining == LEN_W'(1)) state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      sgn_q     <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state_next == RESULT) && (state != RESULT);
      case (state)
        IDLE: if (bus.start) begin
          acc       <= '0;
          ovf_q     <= 1'b0;
          remaining <= bus.len;
          sgn_q     <= bus.signed_mode;
          sat_q     <= bus.saturate;
        end
        ACCUM: if (hs) begin
          acc       <= acc_upd;
          ovf_q     <= ovf_q | too_high | too_low;
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs decode registered state only.
  assign bus.in_ready     = (state == ACCUM);
  assign bus.res_valid    = (state == RESULT);
  assign bus.res_data     = acc;
  assign bus.res_overflow = ovf_q;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pim_mac_array.sv
// Scoreboard bench for pim_mac_array: driver pushes model results, a negedge
// monitor pops them on each result handshake.
`timescale 1ns/1ps
module tb_pim_mac_array;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 9;
  localparam longint MASK = (longint'(1) << ACC_W) - 1;

  typedef logic [LANES*DATA_W-1:0] beat_t;
  typedef struct {
    longint data;
    bit     ovf;
    int     beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pim_mac_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  pim_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic longint lane_val(input logic [DATA_W-1:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reference: exact integer dot product, then clamp or wrap into the result range.
  function automatic exp_t model(input int n, input bit s, input bit sat, input beat_t xs[$], input beat_t ws[$]);
    exp_t   e;
    longint acc, nxt, lo, hi;
    beat_t  xb, wb;
    acc = 0;
    e.ovf = 1'b0;
    e.beats = n;
    lo = s ? -(longint'(1) << (ACC_W-1)) : 0;
    hi = s ? (longint'(1) << (ACC_W-1)) - 1 : MASK;
    for (int b = 0; b < n; b++) begin
      xb = xs[b];
      wb = ws[b];
      nxt = acc;
      for (int i = 0; i < LANES; i++)
        nxt += lane_val(xb[i*DATA_W +: DATA_W], s) * lane_val(wb[i*DATA_W +: DATA_W], s);
      if (nxt > hi || nxt < lo) begin
        e.ovf = 1'b1;
        if (sat) acc = (nxt > hi) ? hi : lo;
        else begin
          acc = nxt & MASK;
          if (s && acc > hi) acc -= (MASK + 1);
        end
      end else acc = nxt;
    end
    e.data = acc & MASK;
    return e;
  endfunction

  function automatic beat_t gen_beat();
    beat_t b;
    logic [DATA_W-1:0] ext [4];
    ext[0] = 8'h00; ext[1] = 8'h7F; ext[2] = 8'h80; ext[3] = 8'hFF;
    for (int i = 0; i < LANES; i++)
      b[i*DATA_W +: DATA_W] = ($urandom_range(0, 1) == 1) ? ext[$urandom_range(0, 3)] : DATA_W'($urandom);
    return b;
  endfunction

  // Monitor
  logic   prev_rv = 1'b0, prev_rdy = 1'b0;
  longint prev_data = 0;
  int     beat_cnt = 0;
  exp_t   mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_cnt = 0;
      prev_rv  = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) beat_cnt++;
      if (bus.res_valid || bus.done)
        check("done_first_valid_cycle", bus.done, bus.res_valid && !prev_rv);
      if (bus.res_valid && prev_rv && !prev_rdy)
        check("res_stable", bus.res_data, prev_data);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL res_unexpected: got result %0d with no pending operation", bus.res_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_data", bus.res_data, mon_e.data);
          check("res_overflow", bus.res_overflow, mon_e.ovf);
          check("beats_accepted", beat_cnt, mon_e.beats);
        end
        beat_cnt = 0;
      end
      prev_rv   = bus.res_valid;
      prev_rdy  = bus.res_ready;
      prev_data = bus.res_data;
    end
  end

  // vmode: 0 valid held high, 1 toggle every other cycle, 2 random
  task automatic run_op(input int n, input bit s, input bit sat, input int vmode, input int rdelay,
                        input bit inject, input bit rnd, input logic [DATA_W-1:0] xc, input logic [DATA_W-1:0] wc);
    beat_t xs[$], ws[$];
    int    k, cyc;
    bit    hs;
    for (int b = 0; b < n; b++) begin
      if (rnd) begin
        xs.push_back(gen_beat());
        ws.push_back(gen_beat());
      end else begin
        xs.push_back({LANES{xc}});
        ws.push_back({LANES{wc}});
      end
    end
    exp_q.push_back(model(n, s, sat, xs, ws));
    bus.start = 1'b1;
    bus.len = LEN_W'(n);
    bus.signed_mode = s;
    bus.saturate = sat;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len = LEN_W'($urandom);
    bus.signed_mode = 1'($urandom);
    bus.saturate = 1'($urandom);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 300) begin
      bus.x_data = xs[k];
      bus.w_data = ws[k];
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.start = inject && (cyc == 1);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    if (k < n) begin
      n_total++;
      $display("FAIL beat_timeout: accepted %0d beats, required %0d", k, n);
    end
    check("res_valid_latency", bus.res_valid, 1);
    for (int d = 0; d < rdelay; d++) begin
      @(posedge clk); #1;
      check("res_valid_held", bus.res_valid, 1);
    end
    bus.res_ready = 1'b1;
    bus.start = inject;
    bus.len = '0;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    check("idle_after_accept", bus.busy, 0);
    check("res_valid_dropped", bus.res_valid, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.signed_mode = 1'b0;
    bus.saturate = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_data = '0;
    bus.w_data = '0;
    bus.res_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res_data", bus.res_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4, 0, 0, 0, 0, 0, 0, 8'd3, 8'd5);      // 240
    run_op(2, 1, 0, 0, 1, 0, 0, 8'h80, 8'd127);   // -130048
    run_op(2, 0, 0, 0, 0, 0, 0, 8'h80, 8'd127);   // 130048
    run_op(5, 0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF);    // clamp to 0xFFFFF
    run_op(5, 0, 0, 0, 2, 0, 0, 8'hFF, 8'hFF);    // wrap to 251924
    run_op(3, 0, 0, 1, 5, 0, 1, 8'h00, 8'h00);    // backpressure
    run_op(4, 1, 0, 0, 0, 1, 1, 8'h00, 8'h00);    // start injected during ACCUM
    run_op(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);    // len 0
    run_op(0, 1, 1, 0, 3, 0, 0, 8'h00, 8'h00);

    // Reset after two of four beats; that operation must vanish.
    bus.start = 1'b1;
    bus.len = LEN_W'(4);
    bus.signed_mode = 1'b0;
    bus.saturate = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x_data = {LANES{8'd9}};
    bus.w_data = {LANES{8'd7}};
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_res_data", bus.res_data, 0);
    check("midrst_res_overflow", bus.res_overflow, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4, 0, 0, 0, 0, 0, 0, 8'd3, 8'd5);

    for (int t = 0; t < 40; t++)
      run_op($urandom_range(0, 12), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
             $urandom_range(0, 3), 1'($urandom), 1'b1, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pim_mac_array.md
Name: pim_mac_array

Overview:
- Multi-lane streaming multiply-accumulate engine for the PIM datapath. Computes a dot product of x and w vectors delivered as LANES element pairs per beat.
- Vector length, signedness and saturation are selected per operation at start.
- Operands arrive over a valid/ready stream from the bank read path. The scalar result is returned over a valid/ready result channel to the PIM controller.

Parameters:
- LANES, 4, element pairs multiplied and summed per accepted beat (power of 2, ≥1)
- DATA_W, 8, width of each x/w element
- ACC_W, 32, accumulator and result width (≥ 2*DATA_W+clog2(LANES)+1)
- LEN_W, 9, width of len port; max beats per operation = 2^LEN_W-1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- len  in  LEN_W  number of beats in operation; latched at start
- signed_mode  in  1  1 = two's-complement operands/accumulator; latched at start
- saturate  in  1  1 = clamp on overflow, 0 = wrap modulo 2^ACC_W; latched at start
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts operand beat
- x_data  in  LANES*DATA_W  x elements, lane i at bits [i*DATA_W +: DATA_W]
- w_data  in  LANES*DATA_W  w elements, same packing
- res_valid  out  1  result valid; held until accepted
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  dot-product result
- res_overflow  out  1  sticky: range exceeded at any beat of this operation
- busy  out  1  high in ACCUM and RESULT
- done  out  1  single-cycle pulse on the first cycle res_valid is high

Behaviour:
- Reset (async, any state incl. mid-operation): state=IDLE; in_ready, res_valid, busy, done, res_overflow = 0; res_data, accumulator, beat counter = 0. Partial operation is discarded.
- States: IDLE, ACCUM, RESULT. in_ready = (state==ACCUM); busy = (state!=IDLE).
- IDLE:
  - start=1 latches len, signed_mode and saturate; clears accumulator and overflow.
  - len>0: next state ACCUM, remaining = len.
  - len==0: next state RESULT directly with res_data=0, res_overflow=0.
- ACCUM: a beat is accepted when in_valid && in_ready.
  - Per accepted beat: beat_sum = Σ x[i]*w[i], exact width, elements sign- or zero-extended per mode.
  - next = acc + beat_sum, computed exactly with ≥2 guard bits.
  - Range is [-2^(ACC_W-1), 2^(ACC_W-1)-1] when signed, [0, 2^ACC_W-1] when unsigned.
  - If next is out of range, res_overflow is set and stays set. With saturate=1, acc clamps to the nearest bound; with saturate=0, acc = next mod 2^ACC_W.
  - Later beats accumulate from the clamped or wrapped value.
  - Cycles with no handshake leave the accumulator and counter unchanged.
  - On the beat that brings remaining to 0: next state RESULT; res_data = updated acc. res_valid=1 and done=1 in the following cycle (1-cycle latency from last beat to result).
- RESULT: res_valid=1; res_data and res_overflow held stable. When res_valid && res_ready, next state IDLE and res_valid drops.
- done is high for exactly one cycle per operation, including len==0 operations.
- start outside IDLE is ignored, with no effect on the current operation. start in the cycle RESULT returns to IDLE is also ignored; the next start is honoured only in IDLE.
- Input changes on len, signed_mode or saturate after start do not affect the running operation.
- No combinational path from in_valid to in_ready, or from res_ready to res_valid.

Test Plan:
- Unsigned, LANES=4, len=4, every lane x=3, w=5, in_valid held high -> 4 consecutive accepts; res_data=240, res_overflow=0; done pulses once, one cycle after the last beat.
- Signed, len=2, all lanes x=-128 (0x80), w=127 -> res_data=-130048 (0xFFFE0400 at ACC_W=32), overflow=0. Same data with signed_mode=0 -> 2*4*128*127 = 130048.
- Instance with ACC_W=20, unsigned, len=5, all lanes x=255, w=255 (260100 per beat, total 1300500): with saturate=1 -> res_data=0xFFFFF, overflow=1. With saturate=0 -> res_data = 1300500 mod 2^20 = 251924, overflow=1.
- Backpressure, len=3: in_valid toggled every other cycle and res_ready held low 5 cycles after res_valid -> exactly 3 beats accepted. Result stays stable while res_ready is low, done pulses only once, IDLE is entered the cycle after res_ready rises.
- start asserted during ACCUM, and start with len=0 -> the first is ignored and the running result is unaffected. len=0 gives res_valid next cycle with res_data=0 and a single done pulse.
- rst_n pulsed low after 2 of 4 beats, then a fresh operation -> outputs return to reset values immediately; the new operation's result excludes the pre-reset beats.
